// File: rtl/packet_rr_arbiter.sv
// Round-robin packet arbiter: one FIFO at a time is granted for a whole
// packet. The arbiter walks the head slot through raddr_in, checks the size
// byte, streams the packet out on packet_out/packet_valid and then pops the
// slot with a one-cycle rinc pulse. Oversize packets are popped without
// being sent and are counted in drop_cnt.
//
// Handshake: packet_valid is a pure strobe with no backpressure. Each cycle
// it is high, packet_out holds one byte of the current packet, in order from
// byte 0 to byte L-1. rinc is a one-hot, single-cycle pop request to the
// granted FIFO. It is raised in the same cycle the last byte is on
// packet_out.
module packet_rr_arbiter #(
  parameter int N           = 4,
  parameter int UWIDTH      = 8,
  parameter int PTR_IN_SZ   = 4,
  parameter int MAX_PAYLOAD = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           rempty,
  input  logic [N*UWIDTH-1:0]    rdata_bus,
  output logic [N-1:0]           rinc,
  output logic [PTR_IN_SZ-1:0]   raddr_in,
  output logic [UWIDTH-1:0]      packet_out,
  output logic                   packet_valid,
  output logic [N-1:0]           grant,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [UWIDTH-1:0]    MAX_SIZE = UWIDTH'(MAX_PAYLOAD);
  localparam logic [PTR_IN_SZ-1:0] SIZE_IDX = PTR_IN_SZ'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SEND    = 3'd2,
    RELEASE = 3'd3,
    WAIT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gidx;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic [UWIDTH-1:0]     lane_byte;
  logic                  drop_q;
  logic [PTR_IN_SZ-1:0]  last_idx;

  // Pick the first requester at or above the RR pointer, else wrap to the lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_found && !rempty[i] && (IW'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!pick_found && !rempty[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  // Select the granted FIFO's byte from the shared data bus.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx == IW'(i)) lane_byte = rdata_bus[i*UWIDTH +: UWIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    rinc    = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (pick_found) state_d = HDR;
      HDR:     if (raddr_in == SIZE_IDX) state_d = (lane_byte > MAX_SIZE) ? RELEASE : SEND;
      SEND:    if (raddr_in == last_idx) state_d = RELEASE;
      RELEASE: begin
        rinc    = grant;
        state_d = WAIT;
      end
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: grant, slot address, output byte, RR pointer and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant        <= '0;
      gidx         <= '0;
      rr_ptr       <= '0;
      raddr_in     <= '0;
      packet_out   <= '0;
      packet_valid <= 1'b0;
      drop_q       <= 1'b0;
      last_idx     <= '0;
      drop_cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          raddr_in     <= '0;
          packet_valid <= 1'b0;
          if (pick_found) begin
            gidx   <= pick_idx;
            grant  <= N'(1) << pick_idx;
            drop_q <= 1'b0;
          end
        end
        HDR: begin
          if (raddr_in == SIZE_IDX) begin
            // Size byte is bounded, so the last index always fits the slot address.
            last_idx <= lane_byte[PTR_IN_SZ-1:0] + PTR_IN_SZ'(3);
            drop_q   <= (lane_byte > MAX_SIZE);
            raddr_in <= '0;
          end else begin
            raddr_in <= raddr_in + 1'b1;
          end
        end
        SEND: begin
          packet_out   <= lane_byte;
          packet_valid <= 1'b1;
          raddr_in     <= (raddr_in == last_idx) ? '0 : raddr_in + 1'b1;
        end
        RELEASE: begin
          packet_valid <= 1'b0;
          grant        <= '0;
          rr_ptr       <= (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
          if (drop_q && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
        default: begin
          packet_valid <= 1'b0;
          raddr_in     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Round-robin output arbiter that shares one outbound packet channel among N packet FIFOs (fifo instances, read side).
- Grants one FIFO at a time for a whole packet and walks its head slot through the shared raddr_in bus.
- Validates the size byte, streams the bytes out with packet_valid, then pops the slot with a one-cycle rinc pulse.
- Sits between the per-port FIFOs and the link serializer, in the read clock domain.

Parameters:
- N, 4, number of requesting FIFOs (2..8).
- UWIDTH, 8, byte width.
- PTR_IN_SZ, 4, in-slot byte address width; a slot holds up to 2^PTR_IN_SZ bytes.
- MAX_PAYLOAD, 12, largest legal size byte; must be at most 2^PTR_IN_SZ-4.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous active-low reset.
- rempty  in  N  per-FIFO empty flag; bit i low means FIFO i holds a packet.
- rdata_bus  in  N*UWIDTH  FIFO i head-slot byte at bits [i*UWIDTH +: UWIDTH]; combinational function of raddr_in.
- rinc  out  N  per-FIFO pop strobe; one-hot, one cycle.
- raddr_in  out  PTR_IN_SZ  shared in-slot byte address to all FIFOs.
- packet_out  out  UWIDTH  outbound byte, registered.
- packet_valid  out  1  packet_out carries a packet byte.
- grant  out  N  one-hot current owner; zero when idle.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  8  count of dropped oversize packets; saturates at 255.

Behaviour:
- Packet format, by byte index: 0 source_id, 1 dest_id, 2 size, 3..size+2 data, size+3 crc. Total length L = size+4.
- Reset (async, rst=0) values: all outputs 0, state IDLE, RR pointer 0, drop_cnt 0. The reset takes effect immediately, including mid-packet; no rinc is issued for an interrupted packet.
- IDLE:
  - If any rempty bit is low, select the first requester at or after the RR pointer, searching upward with wrap.
  - Register the one-hot grant, set raddr_in=0, go to HDR.
  - Otherwise stay in IDLE.
- HDR (3 cycles, raddr_in = 0, 1, 2):
  - Bytes are read silently; packet_valid stays 0.
  - In the raddr_in=2 cycle, sample size from the granted lane.
  - If size > MAX_PAYLOAD: set the drop flag and go to RELEASE.
  - Otherwise set raddr_in=0 and go to SEND.
- SEND:
  - Each cycle, register the granted lane byte into packet_out, set packet_valid=1, and increment raddr_in.
  - After presenting index L-1, go to RELEASE.
  - packet_valid is high for exactly L consecutive cycles, and byte k appears one cycle after raddr_in=k.
- RELEASE (1 cycle):
  - The last byte is on packet_out during this cycle.
  - rinc[g]=1; on drop, increment drop_cnt (saturating).
  - RR pointer becomes g+1 mod N.
  - Go to WAIT.
- WAIT (1 cycle):
  - packet_valid=0 and grant=0.
  - Lets rempty settle after the pop; then return to IDLE.
- Latency: the cycle IDLE first sees a rempty bit low is t; packet_out byte 0 is valid at t+5.
- Back-to-back packets from one FIFO are separated by 3 non-valid cycles (RELEASE-to-IDLE gap, not counting HDR).
- A FIFO is never re-granted ahead of another pending requester; this is strict RR with no starvation.
- rempty changes on non-granted lanes during a packet are ignored until the next IDLE.
- rempty going high on the granted lane mid-packet is ignored; the packet completes.
- size=0 is legal: L=4.
- raddr_in never exceeds L-1, and no index wraps past 2^PTR_IN_SZ-1 because of the MAX_PAYLOAD bound.

Test Plan:
1. Single packet (defaults, N=4): FIFO0 head = 10,160,3,0,1,2,15; rempty[0] falls -> packet_out 10,160,3,0,1,2,15 on 7 consecutive valid cycles starting 5 cycles later; rinc[0] a single pulse in the last-byte cycle; drop_cnt 0.
2. Fairness: all four rempty low from reset, each FIFO holding one size-1 packet -> grants 0,1,2,3 in order, each packet 5 valid bytes; then refill FIFO0 and FIFO2 -> order 0 then 2.
3. Oversize: FIFO1 size byte 13 -> no packet_valid; rinc[1] pulses 4 cycles after grant; drop_cnt=1; the next requester is served normally.
4. Size zero: FIFO3 holds 63,31,0,127 -> exactly 4 valid bytes 63,31,0,127, then rinc[3].
5. No starvation: FIFO0 holds two packets and FIFO1 becomes nonempty during FIFO0's SEND -> FIFO1 is served before FIFO0's second packet.
6. Reset mid-packet: drop rst to 0 during SEND byte 3 -> all outputs 0 immediately, no rinc; after release the same FIFO0 packet is resent in full from byte 0.
